// File: rtl/puzzle_dealer.sv
// 24-game puzzle source: loadable table of four-card sets, LFSR-chosen deal on a valid/ack handshake.
// Define PUZZLE_DEALER_NO_REPEAT_EN to forbid dealing the same index twice in a row.
module puzzle_dealer #(
  parameter int unsigned NUM_W     = 10,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [4*NUM_W-1:0] load_data,
  output logic               load_ready,
  input  logic               clear,
  input  logic               deal_req,
  output logic               deal_valid,
  input  logic               deal_ack,
  output logic [NUM_W-1:0]   num1,
  output logic [NUM_W-1:0]   num2,
  output logic [NUM_W-1:0]   num3,
  output logic [NUM_W-1:0]   num4,
  output logic [IDX_W-1:0]   deal_index,
  output logic [IDX_W:0]     set_count,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StDraw, StRead, StPresent} state_e;

  localparam logic [IDX_W+1:0] RejLimit = (IDX_W + 2)'(2 * DEPTH - 1);
  localparam logic [IDX_W:0]   Full     = (IDX_W + 1)'(DEPTH);

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [IDX_W:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W+1:0]     rej_q, rej_d;
  logic [4*NUM_W-1:0]   out_q, out_d;
  logic [4*NUM_W-1:0]   table_q [DEPTH];
  logic                 we;
  logic [IDX_W-1:0]     cand;
  logic                 cand_ok;
  logic [IDX_W-1:0]     fallback;

`ifdef PUZZLE_DEALER_NO_REPEAT_EN
  logic has_last_q, has_last_d;
`endif

  assign cand = lfsr_q[IDX_W-1:0];

`ifdef PUZZLE_DEALER_NO_REPEAT_EN
  assign cand_ok = ({1'b0, cand} < cnt_q) &&
                   !(has_last_q && (cnt_q > (IDX_W + 1)'(1)) && (cand == last_q));
`else
  assign cand_ok = ({1'b0, cand} < cnt_q);
`endif

  // (last+1) mod count never equals last when count > 1, so one fallback serves both builds
  assign fallback = IDX_W'(({1'b0, last_q} + (IDX_W + 1)'(1)) % cnt_q);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rej_d   = rej_q;
    out_d   = out_q;
    we      = 1'b0;
`ifdef PUZZLE_DEALER_NO_REPEAT_EN
    has_last_d = has_last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          cnt_d = '0;
        end else if (load_valid && (cnt_q < Full)) begin
          we    = 1'b1;
          cnt_d = cnt_q + (IDX_W + 1)'(1);
        end else if (deal_req && (cnt_q != '0)) begin
          rej_d   = '0;
          state_d = StDraw;
        end
      end
      StDraw: begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        if (cand_ok) begin
          idx_d   = cand;
          state_d = StRead;
        end else if (rej_q == RejLimit) begin
          idx_d   = fallback;
          state_d = StRead;
        end else begin
          rej_d = rej_q + (IDX_W + 2)'(1);
        end
      end
      StRead: begin
        out_d   = table_q[idx_q];
        state_d = StPresent;
      end
      StPresent: begin
        if (deal_ack) begin
          last_d  = idx_q;
`ifdef PUZZLE_DEALER_NO_REPEAT_EN
          has_last_d = 1'b1;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      rej_q   <= '0;
      out_q   <= '0;
`ifdef PUZZLE_DEALER_NO_REPEAT_EN
      has_last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rej_q   <= rej_d;
      out_q   <= out_d;
`ifdef PUZZLE_DEALER_NO_REPEAT_EN
      has_last_q <= has_last_d;
`endif
    end
  end

  // Storage is deliberately unreset; set_count gates what is reachable
  always_ff @(posedge clk) begin
    if (we) table_q[cnt_q[IDX_W-1:0]] <= load_data;
  end

  assign load_ready = (state_q == StIdle) && (cnt_q < Full);
  assign deal_valid = (state_q == StPresent);
  assign busy       = (state_q != StIdle);
  assign deal_index = idx_q;
  assign set_count  = cnt_q;
  assign num1       = out_q[NUM_W-1:0];
  assign num2       = out_q[2*NUM_W-1:NUM_W];
  assign num3       = out_q[3*NUM_W-1:2*NUM_W];
  assign num4       = out_q[4*NUM_W-1:3*NUM_W];

endmodule

// File: tb/tb_puzzle_dealer.sv
// Directed, table-driven bench for puzzle_dealer with NUM_W=10, DEPTH=32.
module tb_puzzle_dealer;

  localparam int NW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [4*NW-1:0] load_data;
  logic          load_ready;
  logic          clear;
  logic          deal_req;
  logic          deal_valid;
  logic          deal_ack;
  logic [NW-1:0] num1, num2, num3, num4;
  logic [4:0]    deal_index;
  logic [5:0]    set_count;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [4*NW-1:0] ref_tab [32];

  puzzle_dealer dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .clear      (clear),
    .deal_req   (deal_req),
    .deal_valid (deal_valid),
    .deal_ack   (deal_ack),
    .num1       (num1),
    .num2       (num2),
    .num3       (num3),
    .num4       (num4),
    .deal_index (deal_index),
    .set_count  (set_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          lv;
    logic          clr;
    logic          dr;
    logic          ack;
    logic [4*NW-1:0] d;
    logic [5:0]    cnt;
    logic          bsy;
  } vec_t;

  vec_t vt [9];

  function automatic logic [4*NW-1:0] pack(input int a, input int b, input int c, input int d);
    return {NW'(d), NW'(c), NW'(b), NW'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load(input logic [4*NW-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!deal_valid && n < 200) begin
      step();
      n++;
    end
    chk("deal_timeout", {63'd0, deal_valid}, 64'd1);
  endtask

  task automatic do_deal(output logic [4:0] idx, output logic [4*NW-1:0] nums);
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    wait_valid();
    idx  = deal_index;
    nums = {num4, num3, num2, num1};
    deal_ack = 1'b1;
    step();
    deal_ack = 1'b0;
    chk("valid_drop", {63'd0, deal_valid}, 64'd0);
  endtask

  task automatic load_three();
    ref_tab[0] = pack(2, 4, 8, 10);
    ref_tab[1] = pack(2, 6, 12, 13);
    ref_tab[2] = pack(3, 5, 7, 13);
    for (int i = 0; i < 3; i++) load(ref_tab[i]);
  endtask

  task automatic check_outputs_reset();
    chk("rst_valid", {63'd0, deal_valid}, 64'd0);
    chk("rst_nums", {24'd0, num4, num3, num2, num1}, 64'd0);
    chk("rst_index", {59'd0, deal_index}, 64'd0);
    chk("rst_count", {58'd0, set_count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, load_ready}, 64'd1);
  endtask

  initial begin
    logic [4:0]      idx, prev;
    logic [4*NW-1:0] nums;

    rst = 1'b1; load_valid = 1'b0; load_data = '0; clear = 1'b0;
    deal_req = 1'b0; deal_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_outputs_reset();

    // IDLE priority table: load/clear over deal_req, clear over load, empty deal ignored
    vt[0] = '{1, 0, 0, 0, pack(2, 4, 8, 10), 6'd1, 0};
    vt[1] = '{1, 0, 0, 0, pack(2, 6, 12, 13), 6'd2, 0};
    vt[2] = '{1, 0, 0, 0, pack(3, 5, 7, 13), 6'd3, 0};
    vt[3] = '{1, 1, 0, 0, pack(1, 1, 1, 1), 6'd0, 0};
    vt[4] = '{0, 0, 1, 0, '0, 6'd0, 0};
    vt[5] = '{1, 0, 0, 0, pack(4, 4, 4, 4), 6'd1, 0};
    vt[6] = '{1, 0, 1, 0, pack(5, 5, 5, 5), 6'd2, 0};
    vt[7] = '{0, 1, 1, 0, '0, 6'd0, 0};
    vt[8] = '{0, 0, 0, 1, '0, 6'd0, 0};
    for (int i = 0; i < 9; i++) begin
      load_valid = vt[i].lv; clear = vt[i].clr; deal_req = vt[i].dr;
      deal_ack = vt[i].ack; load_data = vt[i].d;
      step();
      chk($sformatf("vec%0d_count", i), {58'd0, set_count}, {58'd0, vt[i].cnt});
      chk($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, vt[i].bsy});
      chk($sformatf("vec%0d_valid", i), {63'd0, deal_valid}, 64'd0);
    end
    load_valid = 1'b0; clear = 1'b0; deal_req = 1'b0; deal_ack = 1'b0;

    // Scenario 1: exact latency and first index from the seed
    do_reset();
    load_three();
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    chk("lat_n1_valid", {63'd0, deal_valid}, 64'd0);
    chk("lat_n1_busy", {63'd0, busy}, 64'd1);
    chk("lat_n1_ready", {63'd0, load_ready}, 64'd0);
    step();
    chk("lat_n2_valid", {63'd0, deal_valid}, 64'd0);
    step();
    chk("lat_n3_valid", {63'd0, deal_valid}, 64'd1);
    chk("s1_index", {59'd0, deal_index}, 64'd1);
    chk("s1_nums", {24'd0, num4, num3, num2, num1}, {24'd0, pack(2, 6, 12, 13)});

    // Hold in PRESENT with noise on the IDLE-only inputs
    for (int i = 0; i < 10; i++) begin
      load_valid = i[0]; clear = i[1]; deal_req = i[2]; load_data = pack(i, i, i, i);
      step();
      chk("hold_valid", {63'd0, deal_valid}, 64'd1);
      chk("hold_index", {59'd0, deal_index}, 64'd1);
      chk("hold_nums", {24'd0, num4, num3, num2, num1}, {24'd0, pack(2, 6, 12, 13)});
      chk("hold_count", {58'd0, set_count}, 64'd3);
    end
    load_valid = 1'b0; clear = 1'b0; deal_req = 1'b0;
    deal_ack = 1'b1;
    step();
    deal_ack = 1'b0;
    chk("ack_drop", {63'd0, deal_valid}, 64'd0);
    chk("ack_busy", {63'd0, busy}, 64'd0);

    // Reset while presenting, then the same load/deal reproduces index 1
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    wait_valid();
    do_reset();
    check_outputs_reset();
    load_three();
    do_deal(idx, nums);
    chk("rerun_index", {59'd0, idx}, 64'd1);
    chk("rerun_nums", {24'd0, nums}, {24'd0, pack(2, 6, 12, 13)});

    // Fill to DEPTH, saturate, deal from the full table, then clear
    do_reset();
    for (int i = 0; i < 32; i++) begin
      ref_tab[i] = pack(i, i + 1, 100 + i, 1000 - i);
      chk("fill_ready", {63'd0, load_ready}, 64'd1);
      load(ref_tab[i]);
    end
    chk("full_ready", {63'd0, load_ready}, 64'd0);
    chk("full_count", {58'd0, set_count}, 64'd32);
    load(pack(9, 9, 9, 9));
    chk("sat_count", {58'd0, set_count}, 64'd32);
    for (int r = 0; r < 5; r++) begin
      do_deal(idx, nums);
      chk("full_nums", {24'd0, nums}, {24'd0, ref_tab[idx]});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_count", {58'd0, set_count}, 64'd0);

    // Empty table: deal_req ignored
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("empty_busy", {63'd0, busy}, 64'd0);
      chk("empty_valid", {63'd0, deal_valid}, 64'd0);
      step();
    end

    // Two sets: every deal valid; no back-to-back repeat when the feature is built in
    do_reset();
    ref_tab[0] = pack(1, 2, 3, 4);
    ref_tab[1] = pack(5, 6, 7, 8);
    load(ref_tab[0]);
    load(ref_tab[1]);
    prev = '0;
    for (int r = 0; r < 20; r++) begin
      do_deal(idx, nums);
      chk("two_range", {63'd0, (idx < 5'd2)}, 64'd1);
      chk("two_nums", {24'd0, nums}, {24'd0, ref_tab[idx[0]]});
`ifdef PUZZLE_DEALER_NO_REPEAT_EN
      if (r > 0) chk("two_norepeat", {63'd0, (idx != prev)}, 64'd1);
`endif
      prev = idx;
    end

    // One set: always index 0, fallback guarantees progress
    do_reset();
    load(pack(6, 6, 6, 6));
    for (int r = 0; r < 4; r++) begin
      do_deal(idx, nums);
      chk("one_index", {59'd0, idx}, 64'd0);
      chk("one_nums", {24'd0, nums}, {24'd0, pack(6, 6, 6, 6)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puzzle_dealer.md
# puzzle_dealer

Parametrised 24-game puzzle source. It holds a loadable table of up to DEPTH four-card sets and, on request, deals one set chosen pseudo-randomly by an internal LFSR. It presents the set on a valid/ack handshake until the game controller consumes it. It sits between the game controller, which issues `deal_req` and `deal_ack`, and the card-display and arithmetic path, which reads `num1`..`num4`.

## Interface
- `NUM_W`, 10: width of each card value.
- `DEPTH`, 32: table entries; power of two, 2..256.
- `IDX_W`, $clog2(DEPTH): index width.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  load request for one set.
- `load_data`  in  4*NUM_W  packed set: [NUM_W-1:0] = num1 … top slice = num4.
- `load_ready`  out  1  load accepted when `load_valid && load_ready`.
- `clear`  in  1  empties the table (IDLE only).
- `deal_req`  in  1  request a new puzzle.
- `deal_valid`  out  1  `num1`..`num4` and `deal_index` valid.
- `deal_ack`  in  1  consumer accepts the presented set.
- `num1`..`num4`  out  NUM_W each  dealt cards.
- `deal_index`  out  IDX_W  table index of the dealt set.
- `set_count`  out  IDX_W+1  number of loaded sets.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, DRAW, READ and PRESENT.
- **IDLE**
  - `load_ready = (set_count < DEPTH)`.
  - An accepted load writes entry `set_count` and increments `set_count`.
  - `clear` sets `set_count` to 0 and has priority over a same-cycle load.
  - `deal_req` with `set_count != 0` goes to DRAW. Load and `clear` have priority over `deal_req` in the same cycle; the request is then dropped.
  - `deal_req` with `set_count == 0` is ignored.
- **DRAW**
  - Each cycle tests `cand = lfsr[IDX_W-1:0]`, then advances the LFSR.
  - Accept if `cand < set_count` and the no-repeat rule (see Configuration) passes.
  - On accept, latch `cand` as the index and go to READ.
  - After 2*DEPTH consecutive rejections, force `index = (last_index+1) mod set_count` and go to READ.
- **READ**: synchronous table read, one cycle, then go to PRESENT.
- **PRESENT**
  - `deal_valid=1`; outputs are held stable.
  - `deal_ack` records `last_index`, sets `has_last`, and returns to IDLE.
- The LFSR is 16-bit Galois, right-shift: if lsb=1 then `lfsr=(lfsr>>1)^16'hB400`, else `lfsr>>1`. It advances only in DRAW, so deal sequences are deterministic from reset.
- `load_ready=0` outside IDLE. `deal_req`, `clear` and `load_valid` are ignored outside IDLE.
- Table storage is not reset. After reset or `clear`, old contents are unreachable because `set_count=0`.

## Timing
- Reset values:
  - state IDLE, `lfsr=LFSR_SEED`, `set_count=0`;
  - `last_index=0`, `has_last=0`;
  - `deal_valid=0`, `num1..num4=0`, `deal_index=0`;
  - `busy=0`, `load_ready=1`.
- Minimum latency: `deal_req` sampled at edge N gives DRAW in cycle N+1, READ in N+2, and `deal_valid=1` in N+3. Each rejected draw adds one cycle.
- `deal_valid` drops the cycle after the `deal_ack` edge. The earliest next `deal_req` is accepted in that same IDLE cycle.
- `deal_ack` without `deal_valid` is ignored.
- Reset asserted mid-deal abandons the deal at the next edge and returns all outputs to reset values.
- `set_count` saturates at DEPTH (`load_ready` low). It never wraps.

## Configuration
- `PUZZLE_DEALER_NO_REPEAT_EN` defined: DRAW also rejects `cand == last_index` when `has_last && set_count > 1`. The forced fallback index likewise never equals `last_index` when `set_count > 1`.
- `PUZZLE_DEALER_NO_REPEAT_EN` undefined: no repeat check. Consecutive deals may return the same index, and `last_index` is used only by the fallback.

## Test plan
- Reset, load {2,4,8,10}, {2,6,12,13}, {3,5,7,13}, pulse `deal_req` -> `deal_valid` exactly 3 cycles later with `deal_index=1`, nums 2,6,12,13; held until `deal_ack`.
- Load 32 sets with DEPTH=32 -> `load_ready` low after the 32nd, `set_count=32`; 33rd `load_valid` ignored. Then `clear` -> `set_count=0`.
- `set_count=0`, pulse `deal_req` -> `busy` stays 0, `deal_valid` never asserts.
- `set_count=2` with macro defined, 20 deal/ack rounds -> `deal_index` alternates and never repeats consecutively. `set_count=1` -> always index 0, no hang.
- Assert `rst` while in PRESENT -> next cycle `deal_valid=0`, `num1..num4=0`, `set_count=0`, `lfsr` reseeded; the same load/deal as scenario 1 reproduces index 1.
- Hold `deal_ack` low 10 cycles in PRESENT, toggle `load_valid`/`clear`/`deal_req` -> outputs unchanged, `set_count` unchanged.
